cond_status_unit: RTL
=====================

Name: cond_status_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV status register, written from ALU flag outputs (S-bit instructions) or an explicit MSR-style load.
- Evaluates the 4-bit ARM condition field of the next instruction against those flags and returns a registered pass/fail verdict with a valid/ready handshake.
- Stalls on flag hazards and feeds C back to the ALU carry input.

Parameters:
BYPASS, 1, 1 = same-cycle ALU flag write is forwarded into evaluation; 0 = stall one cycle instead
TAG_W, 5, width of the instruction tag carried alongside each verdict
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flag_we  in  1  write alu_flags into status register this cycle
alu_flags  in  4  {N,Z,C,V} from ALU
msr_we  in  1  explicit status register load
msr_data  in  4  {N,Z,C,V} for explicit load
flag_busy  in  1  flag-setting instruction in flight, flags not yet written
cond_valid  in  1  condition request valid
cond  in  4  ARM condition field
cond_tag  in  TAG_W  instruction tag
cond_ready  out  1  request accepted this cycle when high with cond_valid
out_valid  out  1  verdict valid
out_pass  out  1  1 = execute, 0 = squash
out_tag  out  TAG_W  tag of verdict
out_ready  in  1  downstream accepts verdict
flags  out  4  current status register {N,Z,C,V}
carry_out  out  1  flags C bit, to ALU carry input

Behaviour:
- Reset (async, reset_n=0): flags=RESET_FLAGS, out_valid=0, out_pass=0, out_tag=0. Pending request is dropped. Release is synchronous to the next clk edge.
- Status register priority: flag_we over msr_we. If both are high, alu_flags is written and msr_data is ignored. The update is visible on flags the cycle after the write.
- carry_out = flags[1], combinational from the register.
- Condition decode (f = evaluation flags):
  - EQ 0000: Z; NE 0001: !Z
  - CS 0010: C; CC 0011: !C
  - MI 0100: N; PL 0101: !N
  - VS 0110: V; VC 0111: !V
  - HI 1000: C&!Z; LS 1001: !C|Z
  - GE 1010: N==V; LT 1011: N!=V
  - GT 1100: !Z&(N==V); LE 1101: Z|(N!=V)
  - AL 1110: 1; 1111 reserved: 0
- Evaluation flags: alu_flags if flag_we=1 and BYPASS=1; otherwise the flags register. A same-cycle msr_we is never bypassed.
- Hazard: asserted when cond is not 1110/1111 and any of the following holds:
  - flag_busy=1 and flag_we=0, or
  - flag_we=1 and BYPASS=0, or
  - msr_we=1.
  Conditions 1110 and 1111 never stall.
- Handshake:
  - cond_ready = (!out_valid | out_ready) & !hazard.
  - Accept = cond_valid & cond_ready. On accept: out_pass, out_tag, out_valid=1 register at the next edge (latency 1).
  - If out_valid & out_ready and no accept: out_valid→0.
  - If out_valid & !out_ready: out_pass/out_tag held stable.
  - Back-to-back accepts give a continuous stream, one per cycle.
- Requester holds cond/cond_tag stable while cond_valid=1 and cond_ready=0. The unit stores nothing while stalled.
- Flag writes proceed regardless of output backpressure.

Test Plan:
- Reset with RESET_FLAGS=4'b0000, then cond=0001 (NE), out_ready=1 → cond_ready=1; next cycle out_valid=1, out_pass=1, flags=0000.
- flag_we=1, alu_flags=4'b0100 (Z), BYPASS=1, same-cycle cond=0000 (EQ), tag 5'd3 → accepted; next cycle out_pass=1, out_tag=3, flags=0100.
- Same as above with BYPASS=0 → cond_ready=0 for that cycle. Accepted next cycle, out_pass=1.
- flags=4'b1001 (N,V): sweep cond GE, LT, GT, LE, HI → out_pass=1,0,1,0,0. With flag_busy=1 and flag_we=0, cond=1010 stalls while cond=1110 passes immediately.
- out_ready=0 for 3 cycles after a verdict (tag 7) → out_valid/out_pass/out_tag stay constant and cond_ready=0. Raising out_ready accepts the queued request in the same cycle.
- flag_we and msr_we together (alu_flags=0010, msr_data=1111) → flags=0010, carry_out=1. Assert reset_n=0 mid-stream → out_valid=0 immediately and flags=RESET_FLAGS.

Source files
------------

// File: rtl/cond_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_status_unit
// Description : NZCV status register and ARM condition evaluator with a
//               registered, valid/ready-handshaked pass/squash verdict.
// Revision    : 1.0
// ============================================================================
module cond_status_unit #(
   parameter logic       BYPASS      = 1'b1,
   parameter int         TAG_W       = 5,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flag_we,
   input  logic [3:0]       alu_flags,
   input  logic             msr_we,
   input  logic [3:0]       msr_data,
   input  logic             flag_busy,
   input  logic             cond_valid,
   input  logic [3:0]       cond,
   input  logic [TAG_W-1:0] cond_tag,
   output logic             cond_ready,
   output logic             out_valid,
   output logic             out_pass,
   output logic [TAG_W-1:0] out_tag,
   input  logic             out_ready,
   output logic [3:0]       flags,
   output logic             carry_out
);

   logic [3:0]       r_flags;
   logic             r_valid;
   logic             r_pass;
   logic [TAG_W-1:0] r_tag;

   logic [3:0]       w_eval;
   logic             w_n, w_z, w_c, w_v;
   logic             w_pass;
   logic             w_no_stall;
   logic             w_hazard;
   logic             w_accept;

   // Only an ALU write can be forwarded; an MSR load always waits for the register.
   assign w_eval = (flag_we && BYPASS) ? alu_flags : r_flags;
   assign {w_n, w_z, w_c, w_v} = w_eval;

   always_comb begin
      w_pass = 1'b0;
      case (cond)
         4'b0000: w_pass = w_z;
         4'b0001: w_pass = !w_z;
         4'b0010: w_pass = w_c;
         4'b0011: w_pass = !w_c;
         4'b0100: w_pass = w_n;
         4'b0101: w_pass = !w_n;
         4'b0110: w_pass = w_v;
         4'b0111: w_pass = !w_v;
         4'b1000: w_pass = w_c && !w_z;
         4'b1001: w_pass = !w_c || w_z;
         4'b1010: w_pass = (w_n == w_v);
         4'b1011: w_pass = (w_n != w_v);
         4'b1100: w_pass = !w_z && (w_n == w_v);
         4'b1101: w_pass = w_z || (w_n != w_v);
         4'b1110: w_pass = 1'b1;
         default: w_pass = 1'b0;
      endcase
   end

   // AL and the reserved encoding do not read the flags, so they never stall.
   assign w_no_stall = (cond[3:1] == 3'b111);
   assign w_hazard   = !w_no_stall &&
                       ((flag_busy && !flag_we) || (flag_we && !BYPASS) || msr_we);

   assign cond_ready = (!r_valid || out_ready) && !w_hazard;
   assign w_accept   = cond_valid && cond_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_pass  <= 1'b0;
         r_tag   <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_pass  <= w_pass;
         r_tag   <= cond_tag;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_flags <= RESET_FLAGS;
      end else if (flag_we) begin
         r_flags <= alu_flags;
      end else if (msr_we) begin
         r_flags <= msr_data;
      end
   end

   assign out_valid = r_valid;
   assign out_pass  = r_pass;
   assign out_tag   = r_tag;
   assign flags     = r_flags;
   assign carry_out = r_flags[1];

endmodule
`default_nettype wire
